// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// param_sync_fifo : parametrised single-clock FIFO with occupancy count,
//                   threshold flags, overflow/underflow pulses, sticky error.
// Revision 1.0
// ============================================================================
module param_sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              ren,
    input  logic [DATA_W-1:0] din,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    output logic              err_sticky
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;
    logic              overflow_q, underflow_q, err_q;
    logic              overflow_d, underflow_d, err_d;
    logic              wr_ok, rd_ok;

    // Flags decode the count register only; pointers never determine full/empty.
    assign full         = (count_q == C_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= C_AF);
    assign almost_empty = (count_q <= C_AE);

    // A write into a full FIFO is legal when a read frees a slot in the same cycle.
    assign rd_ok = ren & ~empty;
    assign wr_ok = wen & (~full | ren);

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        overflow_d  = wen & full & ~ren;
        underflow_d = ren & empty;
        err_d       = (err_q & ~err_clr) | overflow_d | underflow_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_ok) begin
                dout_q <= mem_q[rptr_q];
                rptr_q <= rptr_q + AW'(1);
            end
            dout_valid_q <= rd_ok;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            err_q        <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign err_sticky = err_q;

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_param_sync_fifo : table-driven directed bench for two FIFO configurations
//                      (8x8 default and 16-bit x 4).
// Revision 1.0
// ============================================================================
module tb_param_sync_fifo;

    typedef struct {
        bit          rst;
        bit          wen;
        bit          ren;
        bit          clr;
        logic [15:0] din;
        int          cnt;
        logic [15:0] dout;
        bit          dv;
        bit          ov;
        bit          un;
        bit          err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (DATA_W=8, DEPTH=8, AF=6, AE=2)
    logic        a_rst = 1'b1, a_wen = 1'b0, a_ren = 1'b0, a_clr = 1'b0;
    logic [7:0]  a_din = '0;
    logic [7:0]  a_dout;
    logic [3:0]  a_count;
    logic        a_dv, a_full, a_empty, a_af, a_ae, a_ov, a_un, a_err;

    // Instance B: DATA_W=16, DEPTH=4 (AF=2, AE=2)
    logic        b_rst = 1'b1, b_wen = 1'b0, b_ren = 1'b0, b_clr = 1'b0;
    logic [15:0] b_din = '0;
    logic [15:0] b_dout;
    logic [2:0]  b_count;
    logic        b_dv, b_full, b_empty, b_af, b_ae, b_ov, b_un, b_err;

    param_sync_fifo u_a (
        .clk(clk), .rst(a_rst), .wen(a_wen), .ren(a_ren), .din(a_din),
        .err_clr(a_clr), .dout(a_dout), .dout_valid(a_dv), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ov), .underflow(a_un), .err_sticky(a_err)
    );

    param_sync_fifo #(.DATA_W(16), .DEPTH(4)) u_b (
        .clk(clk), .rst(b_rst), .wen(b_wen), .ren(b_ren), .din(b_din),
        .err_clr(b_clr), .dout(b_dout), .dout_valid(b_dv), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ov), .underflow(b_un), .err_sticky(b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(bit rst, bit wen, bit ren, bit clr, int din,
                                int cnt, int dout, bit dv, bit ov, bit un, bit err);
        vec_t v;
        v.rst = rst; v.wen = wen; v.ren = ren; v.clr = clr;
        v.din = 16'(din); v.cnt = cnt; v.dout = 16'(dout);
        v.dv = dv; v.ov = ov; v.un = un; v.err = err;
        return v;
    endfunction

    // Applies one vector to the selected instance (the other is held in reset)
    // and compares all outputs one time unit after the edge.
    task automatic run(input vec_t v, input bit sel, input string tag);
        logic [27:0] got, exp;
        int depth, afl;
        depth = sel ? 4 : 8;
        afl   = sel ? 2 : 6;
        if (!sel) begin
            a_rst = v.rst; a_wen = v.wen; a_ren = v.ren; a_clr = v.clr; a_din = v.din[7:0];
            b_rst = 1'b1;  b_wen = 1'b0;  b_ren = 1'b0;  b_clr = 1'b0;
        end else begin
            b_rst = v.rst; b_wen = v.wen; b_ren = v.ren; b_clr = v.clr; b_din = v.din;
            a_rst = 1'b1;  a_wen = 1'b0;  a_ren = 1'b0;  a_clr = 1'b0;
        end
        @(posedge clk);
        #1;
        if (!sel)
            got = {a_count, a_full, a_empty, a_af, a_ae, 8'h00, a_dout,
                   a_dv, a_ov, a_un, a_err};
        else
            got = {1'b0, b_count, b_full, b_empty, b_af, b_ae, b_dout,
                   b_dv, b_ov, b_un, b_err};
        exp = {4'(v.cnt), v.cnt == depth, v.cnt == 0, v.cnt >= afl, v.cnt <= 2,
               v.dout, v.dv, v.ov, v.un, v.err};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d f/e/af/ae=%b dout=%h dv/ov/un/err=%b want cnt=%0d f/e/af/ae=%b dout=%h dv/ov/un/err=%b",
                     tag, got[27:24], got[23:20], got[19:4], got[3:0],
                     exp[27:24], exp[23:20], exp[19:4], exp[3:0]);
        end
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    initial begin
        //                 rst w r clr din  cnt dout dv ov un err
        tbl_a.push_back(mk(1, 0,0,0,  0,   0,  0,  0,0,0,0));
        tbl_a.push_back(mk(0, 1,0,0, 56,   1,  0,  0,0,0,0));
        tbl_a.push_back(mk(0, 1,0,0, 11,   2,  0,  0,0,0,0));
        tbl_a.push_back(mk(0, 1,0,0, 42,   3,  0,  0,0,0,0));
        tbl_a.push_back(mk(0, 1,0,0, 10,   4,  0,  0,0,0,0));
        tbl_a.push_back(mk(0, 1,0,0, 23,   5,  0,  0,0,0,0));
        tbl_a.push_back(mk(0, 1,0,0, 20,   6,  0,  0,0,0,0));
        tbl_a.push_back(mk(0, 1,0,0,  6,   7,  0,  0,0,0,0));
        tbl_a.push_back(mk(0, 1,0,0, 85,   8,  0,  0,0,0,0));
        tbl_a.push_back(mk(0, 1,0,0, 45,   8,  0,  0,1,0,1));  // overflow
        tbl_a.push_back(mk(0, 0,0,0,  0,   8,  0,  0,0,0,1));
        tbl_a.push_back(mk(0, 1,1,0, 12,   8, 56,  1,0,0,1));  // read+write at full
        tbl_a.push_back(mk(0, 0,1,0,  0,   7, 11,  1,0,0,1));
        tbl_a.push_back(mk(0, 0,1,0,  0,   6, 42,  1,0,0,1));
        tbl_a.push_back(mk(0, 0,1,0,  0,   5, 10,  1,0,0,1));
        tbl_a.push_back(mk(0, 0,1,0,  0,   4, 23,  1,0,0,1));
        tbl_a.push_back(mk(0, 0,1,0,  0,   3, 20,  1,0,0,1));
        tbl_a.push_back(mk(0, 0,1,0,  0,   2,  6,  1,0,0,1));
        tbl_a.push_back(mk(0, 0,1,0,  0,   1, 85,  1,0,0,1));
        tbl_a.push_back(mk(0, 0,1,0,  0,   0, 12,  1,0,0,1));
        tbl_a.push_back(mk(0, 0,1,0,  0,   0, 12,  0,0,1,1));  // underflow, dout holds
        tbl_a.push_back(mk(0, 0,0,1,  0,   0, 12,  0,0,0,0));  // err_clr
        tbl_a.push_back(mk(0, 1,1,0, 77,   1, 12,  0,0,1,1));  // empty, both requested
        tbl_a.push_back(mk(0, 0,1,0,  0,   0, 77,  1,0,0,1));
        tbl_a.push_back(mk(0, 0,1,1,  0,   0, 77,  0,0,1,1));  // new error beats clear
        tbl_a.push_back(mk(0, 0,0,1,  0,   0, 77,  0,0,0,0));
        for (int i = 0; i < 20; i++) begin
            tbl_a.push_back(mk(0, 1,0,0, i, 1, (i == 0) ? 77 : i - 1, 0,0,0,0));
            tbl_a.push_back(mk(0, 0,1,0, 0, 0, i,                      1,0,0,0));
        end
        tbl_a.push_back(mk(0, 0,1,0,  0,   0, 19,  0,0,1,1));
        for (int i = 0; i < 5; i++)
            tbl_a.push_back(mk(0, 1,0,0, 100 + i, i + 1, 19, 0,0,0,1));
        tbl_a.push_back(mk(1, 1,1,0, 99,   0,  0,  0,0,0,0));  // reset mid-operation
        tbl_a.push_back(mk(0, 0,1,0,  0,   0,  0,  0,0,1,1));  // nothing was written
        tbl_a.push_back(mk(0, 1,0,0, 55,   1,  0,  0,0,0,1));
        tbl_a.push_back(mk(0, 0,1,0,  0,   0, 55,  1,0,0,1));

        // 16-bit x 4 configuration: fill, overflow, drain head
        tbl_b.push_back(mk(1, 0,0,0,      0, 0,     0, 0,0,0,0));
        tbl_b.push_back(mk(0, 1,0,0, 16'hA038, 1,   0, 0,0,0,0));
        tbl_b.push_back(mk(0, 1,0,0,     11, 2,     0, 0,0,0,0));
        tbl_b.push_back(mk(0, 1,0,0,     42, 3,     0, 0,0,0,0));
        tbl_b.push_back(mk(0, 1,0,0, 16'hBEEF, 4,   0, 0,0,0,0));
        tbl_b.push_back(mk(0, 1,0,0,     45, 4,     0, 0,1,0,1));
        tbl_b.push_back(mk(0, 0,1,0,      0, 3, 16'hA038, 1,0,0,1));
        tbl_b.push_back(mk(0, 1,1,0,  16'h1234, 3, 11, 1,0,0,1));
        tbl_b.push_back(mk(0, 0,1,0,      0, 2,    42, 1,0,0,1));
        tbl_b.push_back(mk(0, 0,1,0,      0, 1, 16'hBEEF, 1,0,0,1));
        tbl_b.push_back(mk(0, 0,1,0,      0, 0, 16'h1234, 1,0,0,1));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl_a.size(); i++)
            run(tbl_a[i], 1'b0, $sformatf("cfgA vec %0d", i));
        for (int i = 0; i < tbl_b.size(); i++)
            run(tbl_b[i], 1'b1, $sformatf("cfgB vec %0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
